interrupt_sequencer: RTL
========================

Name: interrupt_sequencer

Overview:
- Request/priority/service stage of the PIC.
- Captures IR0–IR7 into IRR, applies the OCW1 mask, resolves priority against ISR, raises INT, and runs the two-pulse INTA handshake.
- Drives the control logic's isr_highest_bit, number_of_ack and send_vector_address, and consumes its ocw1, ocw2, level_triggered and auto_eoi.
- Fully synchronous; one clock domain.

Parameters:
- NUM_IR, 8, number of request lines; only 8 is supported (ISR/IRR/vector widths are fixed).
- SPURIOUS_IR, 7, IR index returned when INTA arrives with no valid request.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ir  input  8  interrupt request lines; already synchronous to clk.
- inta_n  input  1  interrupt acknowledge, active low; already synchronous to clk.
- level_triggered  input  1  1 = level mode, 0 = edge mode (ICW1[3]).
- auto_eoi  input  1  automatic EOI enable (ICW4[1]).
- ocw1  input  8  interrupt mask, 1 = masked.
- ocw2  input  8  EOI/rotate command word.
- ocw2_wr  input  1  one-cycle strobe: ocw2 holds a newly written command.
- int_out  output  1  interrupt request to the CPU.
- irr  output  8  interrupt request register.
- isr  output  8  in-service register.
- isr_highest_bit  output  8  one-hot of the granted/highest-priority in-service level.
- number_of_ack  output  2  count of INTA pulses seen in the current sequence (0, 1, 2).
- send_vector_address  output  1  high while the vector must be driven (second INTA low).

Behaviour:
- Reset (asynchronous, rst_n=0): irr, isr, isr_highest_bit = 8'h00; int_out, send_vector_address = 0; number_of_ack = 0; lowest_prio = 3'd7 (IR0 highest); rotate_aeoi = 0; state = IDLE. Reset mid-sequence aborts it; no ISR bit survives.
- Edge detect: ir_q and inta_q are registered copies. Rising edge = ir & ~ir_q. INTA falling edge = inta_q & ~inta_n. INTA rising edge = ~inta_q & inta_n.
- IRR, edge mode: bit i sets on a rising edge of ir[i]. It clears on the first INTA for the granted level, or when ir[i] is low.
- IRR, level mode: irr[i] follows ir[i] with 1-cycle latency; the granted bit is not cleared by INTA.
- Priority order: circular, starting at lowest_prio+1 and wrapping through 7 to 0; lowest_prio is lowest.
- Candidate: highest-priority set bit of irr & ~ocw1.
- int_out (registered, 1-cycle latency) = candidate exists AND (isr == 0 OR candidate outranks every set isr bit).
- Mask changes take effect on int_out one cycle later; masked IRR bits are retained.
- FSM states:
  - IDLE: on INTA falling edge, latch grant = candidate if int_out=1, else SPURIOUS_IR. If int_out=1, set isr[grant] (and clear irr[grant] in edge mode). Set number_of_ack=1 and isr_highest_bit=onehot(grant). Go to ACK1.
  - ACK1: on INTA falling edge, set number_of_ack=2 and send_vector_address=1. Go to ACK2.
  - ACK2: on INTA rising edge, send_vector_address=0 and number_of_ack=0. If auto_eoi=1 and the grant was not spurious, clear isr[grant]; if rotate_aeoi=1, also set lowest_prio=grant. Go to IDLE.
- Outside a sequence, isr_highest_bit = one-hot of the highest-priority set isr bit, or 0 if isr is 0.
- int_out deasserts one cycle after the first INTA edge unless another qualified request remains.
- OCW2 commands, decoded on ocw2_wr from ocw2[7:5] (L = ocw2[2:0]):
  - 001: non-specific EOI; clear the highest-priority isr bit.
  - 011: specific EOI; clear isr[L].
  - 101: rotate on non-specific EOI; clear the highest isr bit h and set lowest_prio = h.
  - 111: rotate on specific EOI; clear isr[L] and set lowest_prio = L.
  - 110: set priority; lowest_prio = L.
  - 100: set rotate_aeoi = 1.
  - 000: clear rotate_aeoi.
  - 010: no operation.
  - EOI with isr == 0 is a no-op, and its rotate part is skipped.
- Simultaneous events:
  - EOI and first INTA in the same cycle: EOI is evaluated on the pre-update ISR. The new grant bit is set after the clear; if both target the same bit, set wins.
  - IR rising edge and INTA clear on the same bit in the same cycle: clear wins.
  - An INTA falling edge in ACK2 is ignored.

Test Plan:
- Edge mode, mask 8'h00, pulse ir[3] -> irr=8'h08, int_out=1 next cycle; two INTA pulses -> isr=8'h08, irr=0, number_of_ack 1 then 2, send_vector_address=1 only during the second low, isr_highest_bit=8'h08.
- ir[5] in service, then ir[2] asserted -> int_out=1 (nests); ir[6] instead -> int_out stays 0 until non-specific EOI (ocw2=8'h20), then isr=0 and int_out=1.
- ocw1=8'h10, ir[4] high -> irr=8'h10, int_out=0; ocw1=8'h00 -> int_out=1 one cycle later.
- auto_eoi=1, rotate_aeoi set (ocw2=8'h80), service ir[0] -> isr=0 after the second INTA rising edge and lowest_prio=0; with ir[0] and ir[1] both pending, ir[1] is granted next.
- INTA sequence with no request -> isr_highest_bit=8'h80, isr unchanged at 0, number_of_ack reaches 2.
- Assert rst_n=0 in ACK1 -> all outputs 0, state IDLE; a later single IR is serviced normally.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - PIC request capture, priority resolution and two-pulse INTA sequencing
module interrupt_sequencer #(
  parameter int         NUM_IR      = 8,
  parameter logic [2:0] SPURIOUS_IR = 3'd7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] ir,
  input  logic              inta_n,
  input  logic              level_triggered,
  input  logic              auto_eoi,
  input  logic [NUM_IR-1:0] ocw1,
  input  logic [7:0]        ocw2,
  input  logic              ocw2_wr,
  output logic              int_out,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr,
  output logic [NUM_IR-1:0] isr_highest_bit,
  output logic [1:0]        number_of_ack,
  output logic              send_vector_address
);

  typedef enum logic [1:0] {S_IDLE, S_ACK1, S_ACK2} state_t;

  // Highest-priority set bit of v; priority runs lp+1, lp+2, ... wrapping, lp lowest.
  function automatic logic [2:0] top_bit(input logic [7:0] v, input logic [2:0] lp);
    logic [2:0] idx;
    logic [2:0] pick;
    pick = lp;
    for (int k = 8; k >= 1; k--) begin
      idx = lp + 3'(k);
      if (v[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Distance from the top of the rotating order; 0 is the highest priority.
  function automatic logic [2:0] rank(input logic [2:0] idx, input logic [2:0] lp);
    return idx - lp - 3'd1;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] ir_q;
  logic       inta_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] hib_q, hib_d;
  logic       int_out_q, int_out_d;
  logic [1:0] nack_q, nack_d;
  logic       sva_q, sva_d;
  logic [2:0] lp_q, lp_d;
  logic [2:0] grant_q, grant_d;
  logic       spur_q, spur_d;
  logic       raeoi_q, raeoi_d;

  logic [7:0] ir_rise;
  logic       inta_fall;
  logic       inta_rise;
  logic [7:0] req;
  logic       cand_vld;
  logic [2:0] cand;
  logic       isr_vld;
  logic [2:0] isr_top;
  logic [2:0] ocw2_cmd;
  logic [2:0] ocw2_lvl;
  logic [7:0] isr_set;
  logic [7:0] isr_clr;
  logic [7:0] irr_clr;
  logic       unused_ocw2;

  assign ir_rise     = ir & ~ir_q;
  assign inta_fall   = inta_q & ~inta_n;
  assign inta_rise   = ~inta_q & inta_n;
  assign req         = irr_q & ~ocw1;
  assign cand_vld    = |req;
  assign cand        = top_bit(req, lp_q);
  assign isr_vld     = |isr_q;
  assign isr_top     = top_bit(isr_q, lp_q);
  assign ocw2_cmd    = ocw2[7:5];
  assign ocw2_lvl    = ocw2[2:0];
  assign unused_ocw2 = ^ocw2[4:3];

  // A request interrupts only if nothing is in service or it outranks everything in service.
  assign int_out_d = cand_vld && (!isr_vld || (rank(cand, lp_q) < rank(isr_top, lp_q)));

  // Register the raw inputs so edges can be detected one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q   <= 8'h00;
      inta_q <= 1'b1;
    end else begin
      ir_q   <= ir;
      inta_q <= inta_n;
    end
  end

  // FSM state and all sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      irr_q     <= 8'h00;
      isr_q     <= 8'h00;
      hib_q     <= 8'h00;
      int_out_q <= 1'b0;
      nack_q    <= 2'd0;
      sva_q     <= 1'b0;
      lp_q      <= 3'd7;
      grant_q   <= SPURIOUS_IR;
      spur_q    <= 1'b1;
      raeoi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      hib_q     <= hib_d;
      int_out_q <= int_out_d;
      nack_q    <= nack_d;
      sva_q     <= sva_d;
      lp_q      <= lp_d;
      grant_q   <= grant_d;
      spur_q    <= spur_d;
      raeoi_q   <= raeoi_d;
    end
  end

  // OCW2 decode, INTA sequencing and IRR/ISR next state.
  always_comb begin
    state_d = state_q;
    nack_d  = nack_q;
    sva_d   = sva_q;
    hib_d   = hib_q;
    grant_d = grant_q;
    spur_d  = spur_q;
    lp_d    = lp_q;
    raeoi_d = raeoi_q;
    isr_set = 8'h00;
    isr_clr = 8'h00;
    irr_clr = 8'h00;

    // EOI commands look at the ISR as it stood before this cycle's grant.
    if (ocw2_wr) begin
      case (ocw2_cmd)
        3'b001: if (isr_vld) isr_clr = onehot(isr_top);
        3'b011: if (isr_vld) isr_clr = onehot(ocw2_lvl);
        3'b101: if (isr_vld) begin
          isr_clr = onehot(isr_top);
          lp_d    = isr_top;
        end
        3'b111: if (isr_vld) begin
          isr_clr = onehot(ocw2_lvl);
          lp_d    = ocw2_lvl;
        end
        3'b110: lp_d = ocw2_lvl;
        3'b100: raeoi_d = 1'b1;
        3'b000: raeoi_d = 1'b0;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (inta_fall) begin
          // A request withdrawn since int_out was raised is answered as spurious.
          if (int_out_q && cand_vld) begin
            grant_d = cand;
            spur_d  = 1'b0;
            isr_set = onehot(cand);
            if (!level_triggered) irr_clr = onehot(cand);
          end else begin
            grant_d = SPURIOUS_IR;
            spur_d  = 1'b1;
          end
          hib_d   = onehot(grant_d);
          nack_d  = 2'd1;
          state_d = S_ACK1;
        end
      end
      S_ACK1: begin
        if (inta_fall) begin
          nack_d  = 2'd2;
          sva_d   = 1'b1;
          state_d = S_ACK2;
        end
      end
      S_ACK2: begin
        if (inta_rise) begin
          nack_d  = 2'd0;
          sva_d   = 1'b0;
          state_d = S_IDLE;
          // An automatic rotation overrides an OCW2 priority change in the same cycle.
          if (auto_eoi && !spur_q) begin
            isr_clr = isr_clr | onehot(grant_q);
            if (raeoi_q) lp_d = grant_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    isr_d = (isr_q & ~isr_clr) | isr_set;
    if (level_triggered) irr_d = ir;
    else                 irr_d = (irr_q | ir_rise) & ir & ~irr_clr;
  end

  assign int_out             = int_out_q;
  assign irr                 = irr_q;
  assign isr                 = isr_q;
  assign number_of_ack       = nack_q;
  assign send_vector_address = sva_q;
  assign isr_highest_bit     = (state_q == S_IDLE) ? (isr_vld ? onehot(isr_top) : 8'h00) : hib_q;

endmodule
